alu_cmd_queue: RTL
==================

# alu_cmd_queue

Command-queue and result-capture stage that sits directly upstream of the 4-bit `alu` and also consumes its output. A producer pushes {opcode, a, b} commands through a valid/ready handshake into a small FIFO. The FIFO head drives the ALU's `a`/`b`/`s` inputs, and the block registers the ALU's 8-bit `y` into a held result slot with its own valid/ready handshake. This replaces open-loop back-to-back opcode writes with an ordered, back-pressured, one-result-per-command stream.

## Interface
Parameters:
- `DEPTH`, 4, command FIFO entries; power of two, 2..16.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  producer has a command.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`.
- `cmd_a`  in  4  operand a.
- `cmd_b`  in  4  operand b.
- `cmd_s`  in  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 mul, 101 pass a, 110 pass b, 111 xor).
- `alu_a`  out  4  to ALU `a`.
- `alu_b`  out  4  to ALU `b`.
- `alu_s`  out  3  to ALU `s`.
- `alu_y`  in  8  from ALU `y` (combinational).
- `res_valid`  out  1  result slot holds a result.
- `res_ready`  in  1  consumer accepts result.
- `res_y`  out  8  captured result.
- `res_s`  out  3  opcode that produced `res_y`.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Push: `cmd_valid && cmd_ready` at an edge writes {s,a,b} at the write pointer. The pointer increments and wraps modulo DEPTH.
- `alu_a/alu_b/alu_s` come from the head FIFO storage register (glitch-free). When the FIFO is empty they are 0.
- Issue condition: `issue = !empty && (!res_valid || res_ready)`.
- On issue:
  - `res_y <= alu_y`, `res_s <= head.s`, `res_valid <= 1`.
  - The head is popped and the read pointer wraps modulo DEPTH.
- Without issue:
  - `res_valid && res_ready` clears `res_valid`.
  - Otherwise `res_y`/`res_s`/`res_valid` hold.
- `res_y`/`res_s` are stable while `res_valid && !res_ready`.
- Simultaneous push and pop in the same cycle: `count` is unchanged and both pointers advance.
- Full: `cmd_ready = 0`. There is no push bypass at full, even when a pop occurs that cycle.
- Empty: no issue, and `res_valid` drains normally.
- The block never modifies `alu_y`. Sub underflow and wide mul values are captured exactly as the ALU produces them (8-bit, e.g. 9-13 = 8'hFC).
- Exactly one result is produced per accepted command, in order.

## Timing
- Reset (`rst` high at an edge): pointers, `count`, `res_valid`, `res_y` and `res_s` all become 0, and `cmd_ready` becomes 1. Queued commands and any held result are discarded.
- Reset mid-stream: the next cycle behaves exactly as post-reset. A command presented during the reset cycle is not accepted.
- Latency with the queue empty and the slot free: a command accepted at edge N is at the head during cycle N+1, captured at edge N+1, and `res_valid` is high in cycle N+2.
- Throughput: one result per cycle while `res_ready` is held high and the FIFO is non-empty.
- Back-pressure: with `res_ready` low the FIFO fills after DEPTH more accepts, then `cmd_ready` drops.

## Configuration
- `ALU_CMD_QUEUE_STATS_EN` defined:
  - Adds output port `done_cnt` [7:0], which increments on every result handshake (`res_valid && res_ready`).
  - It wraps 255→0 and is cleared by `rst`.
  - Also adds output `ovf_seen` (1 bit), which sticks high once any captured `res_y` has bits [7:4] nonzero on an add or sub opcode, until `rst`.
- Not defined: neither port nor its logic exists, and all other behaviour is identical.

## Test plan
- **All eight opcodes:** push a=1101, b=1001 with s=000..111, `res_ready`=1. Required `res_y` sequence: 8'h16, 8'h04, 8'h09, 8'h0D, 8'h75, 8'h0D, 8'h09, 8'h04, on consecutive cycles with matching `res_s`.
- **Latency:** a single push of s=000, a=3, b=4 at edge N gives `res_valid` first high in cycle N+2 with `res_y`=8'h07.
- **Back-pressure and full:**
  - Hold `res_ready`=0 and push 6 commands (DEPTH=4): the first result is held stable, 4 commands queue, `cmd_ready`=0, `count`=4.
  - Release `res_ready`: all 5 results drain in order, one per cycle.
- **Wrap and underflow:** push 10 commands with s=001, a=9, b=13 and random `res_ready`. Every result must be 8'hFC, the count must never exceed 4, and the pointers must wrap without loss or duplication.
- **Mid-stream reset:** with 3 queued commands and a held result, assert `rst` for one cycle. Next cycle: `count`=0, `res_valid`=0, `cmd_ready`=1, and no stale result appears afterwards.
- **Stats, with `ALU_CMD_QUEUE_STATS_EN`:**
  - 260 handshakes leave `done_cnt`=4.
  - Add a=15, b=15 (8'h1E) sets `ovf_seen`=1.
  - Mul 15×15 does not set `ovf_seen`.

Source files
------------

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO feeding a 4-bit ALU plus a held result slot.
// Producer pushes {s,a,b} via cmd_valid/cmd_ready; the FIFO head drives
// alu_a/alu_b/alu_s; alu_y is captured into res_y/res_s with res_valid/res_ready.
// Ports: clk, rst (sync, active-high), cmd_*, alu_*, res_*, count.
// Optional macro ALU_CMD_QUEUE_STATS_EN adds done_cnt[7:0] and ovf_seen.
module alu_cmd_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_a,
   input  logic [3:0]               cmd_b,
   input  logic [2:0]               cmd_s,
   output logic [3:0]               alu_a,
   output logic [3:0]               alu_b,
   output logic [2:0]               alu_s,
   input  logic [7:0]               alu_y,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [7:0]               res_y,
   output logic [2:0]               res_s,
`ifdef ALU_CMD_QUEUE_STATS_EN
   output logic [7:0]               done_cnt,
   output logic                     ovf_seen,
`endif
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [10:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_res_valid;
   logic [7:0]    r_res_y;
   logic [2:0]    r_res_s;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_issue;
   logic [10:0]   w_head;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = cmd_valid && !w_full;
   assign w_issue = !w_empty && (!r_res_valid || res_ready);
   assign w_head  = r_mem[r_rptr];

   // Head comes straight from storage; forced to 0 when nothing is queued.
   assign alu_s = w_empty ? 3'd0 : w_head[10:8];
   assign alu_a = w_empty ? 4'd0 : w_head[7:4];
   assign alu_b = w_empty ? 4'd0 : w_head[3:0];

   assign cmd_ready = !w_full;
   assign res_valid = r_res_valid;
   assign res_y     = r_res_y;
   assign res_s     = r_res_s;
   assign count     = r_count;

   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem[r_wptr] <= {cmd_s, cmd_a, cmd_b};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_issue) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_issue})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Issue refills the slot in the same edge the old result is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_res_valid <= 1'b0;
         r_res_y     <= '0;
         r_res_s     <= '0;
      end else if (w_issue) begin
         r_res_valid <= 1'b1;
         r_res_y     <= alu_y;
         r_res_s     <= w_head[10:8];
      end else if (r_res_valid && res_ready) begin
         r_res_valid <= 1'b0;
      end
   end

`ifdef ALU_CMD_QUEUE_STATS_EN
   logic [7:0] r_done_cnt;
   logic       r_ovf_seen;
   logic       w_ovf;

   // Opcodes 000 (add) and 001 (sub) share s[2:1] == 00.
   assign w_ovf = w_issue && (w_head[10:9] == 2'b00)
                  && (alu_y[7:4] != 4'h0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_done_cnt <= '0;
         r_ovf_seen <= 1'b0;
      end else begin
         if (r_res_valid && res_ready) begin
            r_done_cnt <= r_done_cnt + 8'd1;
         end
         if (w_ovf) begin
            r_ovf_seen <= 1'b1;
         end
      end
   end

   assign done_cnt = r_done_cnt;
   assign ovf_seen = r_ovf_seen;
`endif

endmodule
